// File: rtl/sqrt_arbiter.sv
// rtl/sqrt_arbiter.sv - round-robin arbiter sharing one restoring sqrt core
module sqrt_arbiter #(
    parameter int NREQ    = 4,
    parameter int IDW     = 2,
    parameter int TIMEOUT = 31
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [32*NREQ-1:0] req_d,
    output logic [NREQ-1:0]   req_ready,
    output logic [31:0]       core_d,
    output logic              core_load,
    input  logic              core_busy,
    input  logic              core_ready,
    input  logic [15:0]       core_q,
    input  logic [16:0]       core_r,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [15:0]       rsp_q,
    output logic [16:0]       rsp_r,
    output logic              rsp_err,
    output logic              active
);

    localparam int WDW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t           state_q, state_d;
    logic [IDW-1:0]   last_grant_q, last_grant_d;
    logic [IDW-1:0]   cur_id_q, cur_id_d;
    logic [31:0]      core_d_q, core_d_d;
    logic [WDW-1:0]   wdog_q, wdog_d;
    logic [IDW-1:0]   rsp_id_q, rsp_id_d;
    logic [15:0]      rsp_q_q, rsp_q_d;
    logic [16:0]      rsp_r_q, rsp_r_d;
    logic             rsp_err_q, rsp_err_d;

    logic             grant_found;
    logic [IDW-1:0]   grant_idx;
    logic [NREQ-1:0]  grant_vec;
    logic [31:0]      grant_data;
    logic             core_done;
    logic             wdog_expired;

    assign core_done    = core_ready && !core_busy;
    assign wdog_expired = (wdog_q == WDW'(TIMEOUT));

    // Round-robin search: first pass above the last winner, second pass wraps to the bottom
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        grant_vec   = '0;
        grant_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (!grant_found && req_valid[i] && (i > int'(last_grant_q))) begin
                grant_found  = 1'b1;
                grant_idx    = IDW'(i);
                grant_vec[i] = 1'b1;
                grant_data   = req_d[32*i +: 32];
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (!grant_found && req_valid[i] && (i <= int'(last_grant_q))) begin
                grant_found  = 1'b1;
                grant_idx    = IDW'(i);
                grant_vec[i] = 1'b1;
                grant_data   = req_d[32*i +: 32];
            end
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: one grant per IDLE visit, completion beats watchdog in WAIT
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (grant_found) state_d = S_LOAD;
            S_LOAD: state_d = S_WAIT;
            S_WAIT: if (core_done || wdog_expired) state_d = S_RESP;
            S_RESP: if (rsp_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs; req_ready is suppressed while reset is asserted
    always_comb begin
        req_ready = '0;
        core_load = 1'b0;
        rsp_valid = 1'b0;
        active    = (state_q != S_IDLE);
        case (state_q)
            S_IDLE: if (reset) req_ready = grant_vec;
            S_LOAD: core_load = 1'b1;
            S_RESP: rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // Datapath next-state: capture radicand on grant, result or timeout in WAIT
    always_comb begin
        last_grant_d = last_grant_q;
        cur_id_d     = cur_id_q;
        core_d_d     = core_d_q;
        wdog_d       = wdog_q;
        rsp_id_d     = rsp_id_q;
        rsp_q_d      = rsp_q_q;
        rsp_r_d      = rsp_r_q;
        rsp_err_d    = rsp_err_q;
        case (state_q)
            S_IDLE: begin
                if (grant_found) begin
                    core_d_d     = grant_data;
                    cur_id_d     = grant_idx;
                    last_grant_d = grant_idx;
                end
            end
            S_LOAD: wdog_d = '0;
            S_WAIT: begin
                if (!wdog_expired) wdog_d = wdog_q + 1'b1;
                if (core_done) begin
                    rsp_q_d   = core_q;
                    rsp_r_d   = core_r;
                    rsp_id_d  = cur_id_q;
                    rsp_err_d = 1'b0;
                end else if (wdog_expired) begin
                    rsp_q_d   = '0;
                    rsp_r_d   = '0;
                    rsp_id_d  = cur_id_q;
                    rsp_err_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Datapath registers; last_grant resets to the top index so requester 0 wins first
    always_ff @(posedge clk) begin
        if (!reset) begin
            last_grant_q <= IDW'(NREQ - 1);
            cur_id_q     <= '0;
            core_d_q     <= '0;
            wdog_q       <= '0;
            rsp_id_q     <= '0;
            rsp_q_q      <= '0;
            rsp_r_q      <= '0;
            rsp_err_q    <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            cur_id_q     <= cur_id_d;
            core_d_q     <= core_d_d;
            wdog_q       <= wdog_d;
            rsp_id_q     <= rsp_id_d;
            rsp_q_q      <= rsp_q_d;
            rsp_r_q      <= rsp_r_d;
            rsp_err_q    <= rsp_err_d;
        end
    end

    assign core_d  = core_d_q;
    assign rsp_id  = rsp_id_q;
    assign rsp_q   = rsp_q_q;
    assign rsp_r   = rsp_r_q;
    assign rsp_err = rsp_err_q;

endmodule
